// File: rtl/pool2x2_stream_mc.sv
// Streaming 2x2 / stride-2 max or average pooling over CH parallel lanes.
// Build option: define POOL2X2_RELU_EN to clamp negative results to zero.
module pool2x2_stream_mc #(
  parameter int WIDTH   = 8,
  parameter int COL_NUM = 128,
  parameter int ROW_NUM = 128,
  parameter int CH      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic [CH*WIDTH-1:0] din,
  input  logic                mode,
  output logic [CH*WIDTH-1:0] dout,
  output logic                valid_out,
  output logic                last_out
);
  localparam int CW     = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
  localparam int RW     = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam int HALF_C = COL_NUM / 2;
  localparam int AW     = (HALF_C > 1) ? $clog2(HALF_C) : 1;
  localparam int BW     = WIDTH + 1;
  localparam logic [CW-1:0] COL_LAST      = CW'(COL_NUM - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(ROW_NUM - 1);
  localparam logic [CW-1:0] COL_PAIR_LAST = CW'(2 * HALF_C - 1);
  localparam logic [RW-1:0] ROW_PAIR_LAST = RW'(2 * (ROW_NUM / 2) - 1);

  logic [CW-1:0]       r_col_cnt;
  logic [RW-1:0]       r_row_cnt;
  logic                r_mode;
  logic [CH*WIDTH-1:0] r_pair;
  logic [CH*BW-1:0]    r_mem [HALF_C];
  logic [CH*BW-1:0]    r_buf_q;
  logic [CH*BW-1:0]    r_s1_h;
  logic                r_s1_valid;
  logic                r_s1_last;
  logic                r_s1_mode;
  logic [CH*WIDTH-1:0] r_dout;
  logic                r_valid_out;
  logic                r_last_out;

  logic [AW-1:0]       w_addr;
  logic                w_row_in;
  logic                w_pair_beat;
  logic                w_wr;
  logic                w_emit;
  logic [CH*BW-1:0]    w_h;
  logic [CH*WIDTH-1:0] w_res;

  // With odd ROW_NUM the final row is consumed but never pooled.
  assign w_row_in    = (ROW_NUM % 2 == 0) || (r_row_cnt != ROW_LAST);
  assign w_pair_beat = valid_in && r_col_cnt[0] && w_row_in;
  assign w_wr        = w_pair_beat && !r_row_cnt[0];
  assign w_emit      = w_pair_beat && r_row_cnt[0];
  assign w_addr      = AW'(r_col_cnt >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_cnt <= '0;
      r_row_cnt <= '0;
      r_mode    <= 1'b0;
    end else if (valid_in) begin
      if (r_col_cnt == '0 && r_row_cnt == '0)
        r_mode <= mode;
      if (r_col_cnt == COL_LAST) begin
        r_col_cnt <= '0;
        r_row_cnt <= (r_row_cnt == ROW_LAST) ? '0 : r_row_cnt + 1'b1;
      end else begin
        r_col_cnt <= r_col_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (valid_in && !r_col_cnt[0])
      r_pair <= din;
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[w_addr] <= w_h;
    r_buf_q <= r_mem[w_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_mode   <= 1'b0;
      r_s1_h      <= '0;
      r_dout      <= '0;
      r_valid_out <= 1'b0;
      r_last_out  <= 1'b0;
    end else begin
      r_s1_valid  <= w_emit;
      r_s1_last   <= w_emit && (r_row_cnt == ROW_PAIR_LAST) && (r_col_cnt == COL_PAIR_LAST);
      r_s1_mode   <= r_mode;
      r_s1_h      <= w_h;
      r_valid_out <= r_s1_valid;
      r_last_out  <= r_s1_valid && r_s1_last;
      if (r_s1_valid)
        r_dout <= w_res;
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_lane
    logic signed [BW-1:0]    w_a;
    logic signed [BW-1:0]    w_b;
    logic signed [BW-1:0]    w_hmax;
    logic signed [BW-1:0]    w_hsum;
    logic signed [BW-1:0]    w_bufv;
    logic signed [BW-1:0]    w_s1h;
    logic signed [BW-1:0]    w_vmax;
    logic signed [WIDTH+1:0] w_sum4;
    logic signed [WIDTH-1:0] w_avg;
    logic signed [WIDTH-1:0] w_fin;

    assign w_a    = BW'($signed(r_pair[gi*WIDTH +: WIDTH]));
    assign w_b    = BW'($signed(din[gi*WIDTH +: WIDTH]));
    assign w_hmax = (w_a > w_b) ? w_a : w_b;
    assign w_hsum = w_a + w_b;
    assign w_h[gi*BW +: BW] = r_mode ? w_hsum : w_hmax;

    assign w_bufv = $signed(r_buf_q[gi*BW +: BW]);
    assign w_s1h  = $signed(r_s1_h[gi*BW +: BW]);
    assign w_vmax = (w_bufv > w_s1h) ? w_bufv : w_s1h;
    // Four-pixel sum plus 2 then floor-divide by 4: round half up.
    assign w_sum4 = (WIDTH+2)'(w_bufv) + (WIDTH+2)'(w_s1h) + (WIDTH+2)'(2);
    assign w_avg  = WIDTH'(w_sum4 >>> 2);
    assign w_fin  = r_s1_mode ? w_avg : WIDTH'(w_vmax);
`ifdef POOL2X2_RELU_EN
    assign w_res[gi*WIDTH +: WIDTH] = w_fin[WIDTH-1] ? '0 : w_fin;
`else
    assign w_res[gi*WIDTH +: WIDTH] = w_fin;
`endif
  end

  assign dout      = r_dout;
  assign valid_out = r_valid_out;
  assign last_out  = r_last_out;
endmodule

// File: doc/pool2x2_stream_mc.md
Name: pool2x2_stream_mc

Overview:
- Streaming 2x2 / stride-2 pooling stage for raster-ordered feature maps; sits between a conv/activation stage and the next layer's input buffer.
- Generalises the single-channel 8-bit max pool:
  - parametrised width, frame size and lane count;
  - runtime max/average mode;
  - frame-end marker;
  - fixed output latency independent of input gaps.
- Single row buffer of COL_NUM/2 partial results per lane. No backpressure.

Parameters:
- WIDTH, 8, signed data width per lane
- COL_NUM, 128, input pixels per row (>=2)
- ROW_NUM, 128, input rows per frame (>=2)
- CH, 1, parallel channel lanes; all lanes share counters and timing

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  din carries one pixel (all CH lanes) this cycle
- din  in  CH*WIDTH  lane k at bits [k*WIDTH +: WIDTH], signed two's complement
- mode  in  1  0 = max, 1 = average; sampled at frame start
- dout  out  CH*WIDTH  pooled result, same lane packing
- valid_out  out  1  one-cycle pulse per pooled pixel
- last_out  out  1  high with valid_out on the final pooled pixel of a frame

Behaviour:
- Reset (synchronous, active-high):
  - dout=0, valid_out=0, last_out=0.
  - Column/row counters = 0; mode register = 0 (max).
  - Row buffer is not cleared.
- Counting:
  - col_cnt advances only on valid_in; wraps COL_NUM-1 -> 0 and increments row_cnt.
  - row_cnt wraps ROW_NUM-1 -> 0 (frame end).
  - Cycles with valid_in=0 freeze all state except the output pipeline.
- Mode latch:
  - mode is registered on the valid_in beat with col_cnt=0 and row_cnt=0.
  - Mode changes mid-frame have no effect until the next frame start.
- Horizontal pair: even col_cnt beat held in a pair register; odd col_cnt beat combines with it.
  - Max mode: h = max(a,b), WIDTH bits.
  - Avg mode: h = a+b, sign-extended to WIDTH+1 bits.
- Row handling:
  - Even row_cnt: h written to buffer entry col_cnt>>1. No output.
  - Odd row_cnt: buffer entry col_cnt>>1 read and combined with h.
    - Max mode: max(buf,h).
    - Avg mode: s = buf+h in WIDTH+2 bits; result = (s+2)>>>2 (arithmetic shift, round half up). Result always fits WIDTH; no saturation needed.
- Latency: valid_out asserts exactly 2 clk cycles after the valid_in beat carrying the bottom-right pixel of each 2x2 window, regardless of later gaps.
  - dout holds its value until the next valid_out.
  - At most one valid_out per input beat; output rate <= 1/4 of input rate.
- Odd sizes:
  - If COL_NUM is odd, the last column of each row is consumed but ignored (floor).
  - If ROW_NUM is odd, the last row is consumed, never written to the buffer, and produces no output.
- last_out: asserted with the valid_out of window (row pair ROW_NUM/2-1, column pair COL_NUM/2-1).
- Back-to-back frames: supported with no idle cycles. The next frame's first beat may arrive in the cycle after the previous frame's last beat.
- Reset mid-frame:
  - Pending outputs are discarded; counters restart at pixel (0,0).
  - Stale buffer contents are never read, because every even row overwrites its entries before the odd row reads them.
- Lanes are fully independent in arithmetic; identical timing.

Optional Feature:
- Macro: POOL2X2_RELU_EN.
  - Defined: each lane's final result is clamped to 0 when negative, before registering into dout. Applies in both modes.
  - Undefined: signed results pass unmodified; no clamp logic instantiated.

Test Plan:
- Max, basic (WIDTH=8, COL_NUM=4, ROW_NUM=4, CH=1, mode=0, continuous valid_in):
  - Stimulus: row0 = 1,-5,3,7; row1 = 2,0,-8,-1.
  - Required: valid_out pulses 2 cycles after the row1 col1 beat and after the row1 col3 beat, with dout 2 then 7; last_out=0 on both.
- Average with rounding (mode=1, same config):
  - Stimulus: row0 = 4,8,-128,-128; row1 = 4,8,-128,-127.
  - Required: dout 6 (sum 24) then -128 (sum -511); no overflow.
- Gapped input:
  - Stimulus: same data as the max-basic case with valid_in low for 3 cycles between every beat.
  - Required: identical dout sequence; each valid_out exactly 2 cycles after its bottom-right beat; no spurious pulses.
- Frame end and mode switch (ROW_NUM=4):
  - Stimulus: two frames back-to-back, mode toggled mid-frame 1 and held for frame 2.
  - Required: frame 1 entirely max mode; frame 2 in the new mode; last_out high only on the 4th output of each frame.
- Multi-lane, odd size, reset (CH=4, COL_NUM=5, ROW_NUM=5):
  - Stimulus: distinct per-lane data; rst pulsed mid-row 2, then a full frame.
  - Required:
    - 4 outputs per frame; column 4 and row 4 are ignored.
    - No valid_out is produced from pre-reset data.
    - Post-reset results match the per-lane golden model.
- Macro check with POOL2X2_RELU_EN defined:
  - Stimulus: a window with all inputs -3.
  - Required: dout=0 in both modes. With the macro undefined: dout=-3 (max) and -3 (avg: (-12+2)>>>2 = -3).
